// File: rtl/branch_resolver_if.sv
`default_nettype none
// ============================================================================
// branch_resolver_if : ALU-flag and branch-request bundle for branch_resolver
// Revision 1.0 - initial release
// ============================================================================
interface branch_resolver_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
);
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              alu_ovf;
  logic              flag_we;
  logic              br_valid;
  logic [2:0]        br_cond;
  logic              br_abs;
  logic [PC_W-1:0]   pc_in;
  logic [PC_W-1:0]   br_offset;
  logic              br_ready;
  logic              br_done;
  logic              br_taken;
  logic [PC_W-1:0]   br_pc;
  logic              flush;
  logic              flag_z;
  logic              flag_n;
  logic              flag_c;
  logic              flag_v;

  modport master (
    output alu_result, alu_carry, alu_ovf, flag_we,
    output br_valid, br_cond, br_abs, pc_in, br_offset,
    input  br_ready, br_done, br_taken, br_pc, flush,
    input  flag_z, flag_n, flag_c, flag_v
  );

  modport slave (
    input  alu_result, alu_carry, alu_ovf, flag_we,
    input  br_valid, br_cond, br_abs, pc_in, br_offset,
    output br_ready, br_done, br_taken, br_pc, flush,
    output flag_z, flag_n, flag_c, flag_v
  );
endinterface
`default_nettype wire

// File: rtl/branch_resolver.sv
`default_nettype none
// ============================================================================
// branch_resolver : condition-flag register, branch evaluation and flush timer
// Revision 1.0 - initial release
// ============================================================================
module branch_resolver #(
  parameter int DATA_W       = 32,
  parameter int PC_W         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  branch_resolver_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_t          state_q, state_d;
  logic [2:0]      flush_cnt_q, flush_cnt_d;
  logic            flush_q, flush_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic            taken_q, taken_d;
  logic [PC_W-1:0] br_pc_q, br_pc_d;
  logic            z_q, n_q, c_q, v_q;
  logic            z_d, n_d, c_d, v_d;

  logic            new_z, new_n;
  logic            eff_z, eff_n, eff_c, eff_v;
  logic            cond_hit;
  logic [PC_W-1:0] target;

  // Same-cycle flag writes are forwarded into the condition evaluation.
  always_comb begin
    new_z  = (bus.alu_result == '0);
    new_n  = bus.alu_result[DATA_W-1];
    eff_z  = bus.flag_we ? new_z         : z_q;
    eff_n  = bus.flag_we ? new_n         : n_q;
    eff_c  = bus.flag_we ? bus.alu_carry : c_q;
    eff_v  = bus.flag_we ? bus.alu_ovf   : v_q;
    target = bus.br_abs ? bus.br_offset : (bus.pc_in + bus.br_offset);
    case (bus.br_cond)
      3'b000:  cond_hit = 1'b1;
      3'b001:  cond_hit = eff_n;
      3'b010:  cond_hit = eff_z;
      3'b011:  cond_hit = !eff_z;
      3'b100:  cond_hit = !eff_n;
      3'b101:  cond_hit = eff_c;
      3'b110:  cond_hit = eff_v;
      default: cond_hit = !eff_z && !eff_n;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    done_d      = 1'b0;
    taken_d     = 1'b0;
    br_pc_d     = br_pc_q;
    z_d         = z_q;
    n_d         = n_q;
    c_d         = c_q;
    v_d         = v_q;
    case (state_q)
      IDLE: begin
        if (bus.flag_we) begin
          z_d = new_z;
          n_d = new_n;
          c_d = bus.alu_carry;
          v_d = bus.alu_ovf;
        end
        if (bus.br_valid) begin
          done_d  = 1'b1;
          taken_d = cond_hit;
          if (cond_hit) begin
            br_pc_d     = target;
            state_d     = FLUSH;
            flush_cnt_d = FLUSH_LOAD;
          end
        end
      end
      FLUSH: begin
        flush_cnt_d = flush_cnt_q - 3'd1;
        if (flush_cnt_q == 3'd1) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered copies of the next state keep flush/ready free of input paths.
    flush_d = (state_d == FLUSH);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      flush_cnt_q <= 3'd0;
      flush_q     <= 1'b0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      taken_q     <= 1'b0;
      br_pc_q     <= '0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      flush_q     <= flush_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      taken_q     <= taken_d;
      br_pc_q     <= br_pc_d;
      z_q         <= z_d;
      n_q         <= n_d;
      c_q         <= c_d;
      v_q         <= v_d;
    end
  end

  assign bus.br_ready = ready_q;
  assign bus.br_done  = done_q;
  assign bus.br_taken = taken_q;
  assign bus.br_pc    = br_pc_q;
  assign bus.flush    = flush_q;
  assign bus.flag_z   = z_q;
  assign bus.flag_n   = n_q;
  assign bus.flag_c   = c_q;
  assign bus.flag_v   = v_q;

endmodule
`default_nettype wire
